uart_rx_buffered: RTL and testbench

- UART receiver with a receive FIFO on the peripheral side of the UART block.
- Deserialises start/8-data/optional-parity/stop frames from the serial line and pushes good bytes into a 2^W-entry FIFO.
- The host pops bytes with a one-cycle read strobe.
- Pairs with the team's buffered UART transmitter; both must use identical P, s and TIMER.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/uart_rx_buffered.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_buffered.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART receiver: parity encodings, FSM states
// and the parity check helper.
package uart_pkg;

    localparam int DATA_W   = 8;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rxState_t;

    // True when the received parity bit does not give the weight the mode demands.
    function automatic logic parityBad(input logic [DATA_W-1:0] data,
                                       input logic              parBit,
                                       input int                mode);
        logic weightOdd;
        weightOdd = ^{data, parBit};
        if (mode == PAR_ODD)
            parityBad = ~weightOdd;
        else if (mode == PAR_EVEN)
            parityBad = weightOdd;
        else
            parityBad = 1'b0;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO, 2^AW entries, with registered empty/full flags.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_wData,
    output logic [DW-1:0] o_rData,
    output logic          o_empty,
    output logic          o_full
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic          r_empty;
    logic          r_full;

    logic          w_doPop;
    logic          w_doPush;
    logic [AW:0]   w_nextCount;

    assign w_doPop  = i_pop & ~r_empty;
    assign w_doPush = i_push & (~r_full | w_doPop);

    always_comb begin
        w_nextCount = r_count;
        if (w_doPush && !w_doPop)
            w_nextCount = r_count + (AW+1)'(1);
        else if (w_doPop && !w_doPush)
            w_nextCount = r_count - (AW+1)'(1);
    end

    // Storage is cleared on reset so the head reads 0 straight out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= i_wData;
                r_wrPtr        <= r_wrPtr + AW'(1);
            end
            if (w_doPop)
                r_rdPtr <= r_rdPtr + AW'(1);
            r_count <= w_nextCount;
            r_empty <= (w_nextCount == '0);
            r_full  <= (w_nextCount == (AW+1)'(DEPTH));
        end
    end

    assign o_rData = r_mem[r_rdPtr];
    assign o_empty = r_empty;
    assign o_full  = r_full;

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver (start/8 data/optional parity/stop) feeding a receive FIFO.
// Optional macro UART_RX_SYNC_EN adds a two-flop synchroniser on rx.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int P     = 0,
    parameter int W     = 2,
    parameter int s     = 1,
    parameter int TIMER = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic              rd,
    output logic [DATA_W-1:0] r_data,
    output logic              empty,
    output logic              full,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun_err
);

    localparam int             TW        = (TIMER > 2) ? $clog2(TIMER) : 1;
    localparam logic [TW-1:0]  LAST_TICK = TW'(TIMER - 1);
    localparam logic [TW-1:0]  HALF_TICK = TW'(TIMER / 2 - 1);
    localparam logic [2:0]     LAST_STOP = 3'(s - 1);

    logic w_rx;

`ifdef UART_RX_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_sync <= 2'b11;
        else
            r_sync <= {r_sync[0], rx};
    end

    assign w_rx = r_sync[1];
`else
    assign w_rx = rx;
`endif

    rxState_t          r_state,   w_state;
    logic [TW-1:0]     r_timer,   w_timer;
    logic [2:0]        r_bitCnt,  w_bitCnt;
    logic [DATA_W-1:0] r_shift,   w_shift;
    logic              r_parBad,  w_parBad;
    logic              r_stopBad, w_stopBad;
    logic              r_done,    w_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_bitCnt  <= '0;
            r_shift   <= '0;
            r_parBad  <= 1'b0;
            r_stopBad <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_timer   <= w_timer;
            r_bitCnt  <= w_bitCnt;
            r_shift   <= w_shift;
            r_parBad  <= w_parBad;
            r_stopBad <= w_stopBad;
            r_done    <= w_done;
        end
    end

    // Every sample lands on a mid-bit tick; r_done marks the end-of-frame cycle.
    always_comb begin
        w_state   = r_state;
        w_timer   = r_timer;
        w_bitCnt  = r_bitCnt;
        w_shift   = r_shift;
        w_parBad  = r_parBad;
        w_stopBad = r_stopBad;
        w_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx) begin
                    w_state   = START;
                    w_timer   = '0;
                    w_bitCnt  = '0;
                    w_parBad  = 1'b0;
                    w_stopBad = 1'b0;
                end
            end
            START: begin
                if (r_timer == HALF_TICK) begin
                    w_timer = '0;
                    w_state = w_rx ? IDLE : DATA;
                end else begin
                    w_timer = r_timer + TW'(1);
                end
            end
            DATA: begin
                if (r_timer == LAST_TICK) begin
                    w_timer  = '0;
                    w_shift  = {w_rx, r_shift[DATA_W-1:1]};
                    w_bitCnt = r_bitCnt + 3'd1;
                    if (r_bitCnt == 3'd7) begin
                        w_bitCnt = '0;
                        w_state  = (P != PAR_NONE) ? PARITY : STOP;
                    end
                end else begin
                    w_timer = r_timer + TW'(1);
                end
            end
            PARITY: begin
                if (r_timer == LAST_TICK) begin
                    w_timer  = '0;
                    w_parBad = parityBad(r_shift, w_rx, P);
                    w_state  = STOP;
                end else begin
                    w_timer = r_timer + TW'(1);
                end
            end
            STOP: begin
                if (r_timer == LAST_TICK) begin
                    w_timer   = '0;
                    w_stopBad = r_stopBad | ~w_rx;
                    if (r_bitCnt == LAST_STOP) begin
                        w_bitCnt = '0;
                        w_done   = 1'b1;
                        w_state  = IDLE;
                    end else begin
                        w_bitCnt = r_bitCnt + 3'd1;
                    end
                end else begin
                    w_timer = r_timer + TW'(1);
                end
            end
            default: begin
                w_state = IDLE;
                w_timer = '0;
            end
        endcase
    end

    logic w_good;
    logic w_fifoEmpty;
    logic w_fifoFull;

    assign w_good = r_done & ~r_stopBad & ~r_parBad;

    sync_fifo #(
        .DW(DATA_W),
        .AW(W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_good),
        .i_pop   (rd),
        .i_wData (r_shift),
        .o_rData (r_data),
        .o_empty (w_fifoEmpty),
        .o_full  (w_fifoFull)
    );

    // A simultaneous pop frees a slot, so a good byte arriving while full is kept.
    assign overrun_err = w_good & w_fifoFull & ~rd;
    assign frame_err   = r_done & r_stopBad;
    assign parity_err  = r_done & r_parBad;
    assign empty       = w_fifoEmpty;
    assign full        = w_fifoFull;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered: one instance without parity, one with even parity,
// both W=2, s=2, TIMER=5, checked against a queue-based reference model.
module tb_uart_rx_buffered;

    localparam int TIMER = 5;
    localparam int STOPS = 2;
    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       rxL   [2];
    logic       rdL   [2];
    logic [7:0] rData [2];
    logic       emptyL[2];
    logic       fullL [2];
    logic       fErr  [2];
    logic       pErr  [2];
    logic       oErr  [2];

    int checks;
    int errors;

    int nFrame[2];
    int nPar  [2];
    int nOvr  [2];
    int nWide;
    int expFrame[2];
    int expPar  [2];
    int expOvr  [2];

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    uart_rx_buffered #(.P(0), .W(2), .s(STOPS), .TIMER(TIMER)) dutNone (
        .clk        (clk),
        .reset      (reset),
        .rx         (rxL[0]),
        .rd         (rdL[0]),
        .r_data     (rData[0]),
        .empty      (emptyL[0]),
        .full       (fullL[0]),
        .frame_err  (fErr[0]),
        .parity_err (pErr[0]),
        .overrun_err(oErr[0])
    );

    uart_rx_buffered #(.P(2), .W(2), .s(STOPS), .TIMER(TIMER)) dutEven (
        .clk        (clk),
        .reset      (reset),
        .rx         (rxL[1]),
        .rd         (rdL[1]),
        .r_data     (rData[1]),
        .empty      (emptyL[1]),
        .full       (fullL[1]),
        .frame_err  (fErr[1]),
        .parity_err (pErr[1]),
        .overrun_err(oErr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] prevPulse;
    initial prevPulse = '0;

    // Counts error pulses and notices any pulse that lasts longer than one cycle.
    always @(negedge clk) begin
        logic [5:0] cur;
        cur = {fErr[0], pErr[0], oErr[0], fErr[1], pErr[1], oErr[1]};
        for (int k = 0; k < 2; k++) begin
            if (fErr[k] === 1'b1) nFrame[k]++;
            if (pErr[k] === 1'b1) nPar[k]++;
            if (oErr[k] === 1'b1) nOvr[k]++;
        end
        if ((cur & prevPulse) != 0) nWide++;
        prevPulse = cur;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int modelSize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [7:0] modelHead(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    task automatic modelPush(input int d, input logic [7:0] b);
        if (d == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    task automatic modelPop(input int d);
        if (d == 0) begin
            if (q0.size() > 0) void'(q0.pop_front());
        end else begin
            if (q1.size() > 0) void'(q1.pop_front());
        end
    endtask

    // Serialises one frame on line d and books its expected outcome in the model.
    task automatic applyStimulus(input int d, input logic [7:0] data,
                                 input bit parFlip, input bit stopLow);
        logic bits[$];
        bit   parOn;
        parOn = (d == 1);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (parOn) bits.push_back((^data) ^ parFlip);
        for (int i = 0; i < STOPS; i++) bits.push_back((i == 0) ? ~stopLow : 1'b1);

        if (stopLow) expFrame[d]++;
        if (parOn && parFlip) expPar[d]++;
        if (!stopLow && !(parOn && parFlip)) begin
            if (modelSize(d) == DEPTH) expOvr[d]++;
            else modelPush(d, data);
        end

        foreach (bits[i]) begin
            rxL[d] = bits[i];
            repeat (TIMER) @(negedge clk);
        end
        rxL[d] = 1'b1;
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    task automatic popOne(input int d);
        rdL[d] = 1'b1;
        @(negedge clk);
        rdL[d] = 1'b0;
        modelPop(d);
    endtask

    task automatic checkState(input int d, input string tag);
        int sz;
        sz = modelSize(d);
        checkOutput($sformatf("%s.d%0d.empty", tag, d), emptyL[d], sz == 0);
        checkOutput($sformatf("%s.d%0d.full", tag, d), fullL[d], sz == DEPTH);
        if (sz > 0)
            checkOutput($sformatf("%s.d%0d.head", tag, d), rData[d], modelHead(d));
        checkOutput($sformatf("%s.d%0d.frameErr", tag, d), nFrame[d], expFrame[d]);
        checkOutput($sformatf("%s.d%0d.parityErr", tag, d), nPar[d], expPar[d]);
        checkOutput($sformatf("%s.d%0d.overrun", tag, d), nOvr[d], expOvr[d]);
    endtask

    initial begin
        logic [7:0] fillBytes [4];
        checks = 0;
        errors = 0;
        nWide  = 0;
        for (int k = 0; k < 2; k++) begin
            nFrame[k] = 0; nPar[k] = 0; nOvr[k] = 0;
            expFrame[k] = 0; expPar[k] = 0; expOvr[k] = 0;
            rxL[k] = 1'b1;
            rdL[k] = 1'b0;
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("reset.d%0d.empty", k), emptyL[k], 1);
            checkOutput($sformatf("reset.d%0d.full", k), fullL[k], 0);
            checkOutput($sformatf("reset.d%0d.rData", k), rData[k], 0);
            checkOutput($sformatf("reset.d%0d.pulses", k),
                        {fErr[k], pErr[k], oErr[k]}, 0);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);

        fillBytes = '{8'h05, 8'h06, 8'h07, 8'h0F};
        foreach (fillBytes[i]) applyStimulus(0, fillBytes[i], 0, 0);
        settle();
        checkState(0, "fill");

        applyStimulus(0, 8'hAA, 0, 0);
        settle();
        checkState(0, "overrun");

        for (int i = 0; i < 4; i++) begin
            popOne(0);
            checkState(0, $sformatf("pop%0d", i));
        end
        popOne(0);
        checkState(0, "popEmpty");
        applyStimulus(0, 8'h5A, 0, 0);
        settle();
        checkState(0, "afterEmptyPop");
        popOne(0);

        applyStimulus(0, 8'h81, 0, 1);
        settle();
        checkState(0, "stopLow");

        rxL[0] = 1'b0;
        @(negedge clk);
        rxL[0] = 1'b1;
        repeat (12) @(negedge clk);
        checkState(0, "glitch");
        applyStimulus(0, 8'hC3, 0, 0);
        settle();
        checkState(0, "postGlitch");
        popOne(0);

        applyStimulus(0, 8'h11, 0, 0);
        applyStimulus(0, 8'h22, 0, 0);
        settle();
        checkState(0, "preReset");
        rxL[0] = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("midReset.empty", emptyL[0], 1);
        checkOutput("midReset.full", fullL[0], 0);
        checkOutput("midReset.rData", rData[0], 0);
        q0.delete();
        q1.delete();
        rxL[0] = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        applyStimulus(0, 8'h3C, 0, 0);
        settle();
        checkState(0, "postReset");

        applyStimulus(1, 8'hAB, 1, 0);
        settle();
        checkState(1, "badParity");
        applyStimulus(1, 8'hAB, 0, 0);
        settle();
        checkState(1, "goodParity");

        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            bit pf;
            bit sl;
            b  = 8'($urandom);
            pf = ($urandom_range(0, 4) == 0);
            sl = ($urandom_range(0, 5) == 0);
            applyStimulus(1, b, pf, sl);
            if ($urandom_range(0, 3) != 0) settle();
            else applyStimulus(1, 8'($urandom), 0, 0);
            settle();
            checkState(1, $sformatf("rand%0d", i));
            if ($urandom_range(0, 2) == 0) begin
                popOne(1);
                checkState(1, $sformatf("randPop%0d", i));
            end
        end

        checkOutput("pulseWidth", nWide, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
